pid_fast_stretch: RTL and testbench
===================================

PID_FAST_STRETCH -- requirements
Module: pid_fast_stretch

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8: clocks per USB bit period; legal range 2..255.
REQ-002 SHALL have parameter DEPTH, default 4: pending-PID queue entries; power of two, 2..16.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port fast_enable, input, 1: single-cycle request pulse from TRCU.
REQ-006 SHALL have port pid_in, input, 4: PID nibble, sampled when fast_enable=1.
REQ-007 SHALL have port slow_enable, output, 1: enable held one bit period per accepted request.
REQ-008 SHALL have port pid_out, output, 8: {~pid, pid} for the PID being presented; valid while slow_enable=1.
REQ-009 SHALL have port pending, output, $clog2(DEPTH)+1: queued requests not yet presented.
REQ-010 SHALL have port overflow, output, 1: sticky flag for a dropped request.

Function
REQ-011 SHALL push {pid_in} into the queue on every clock with fast_enable=1 and queue not full.
REQ-012 SHALL implement states IDLE, HOLD and GAP.
REQ-013 IDLE: if pending>0, SHALL pop the head and enter HOLD next clock; otherwise remain in IDLE.
REQ-014 HOLD: SHALL drive slow_enable=1 for exactly CLKS_PER_BIT consecutive clocks, then enter GAP.
REQ-015 GAP: SHALL drive slow_enable=0 for exactly CLKS_PER_BIT clocks, then enter IDLE.
REQ-016 Latency: fast_enable at clock t into an empty queue in IDLE SHALL give slow_enable=1 from clock t+2.
REQ-017 Back-to-back requests SHALL yield slow_enable pulses whose rising edges are 2*CLKS_PER_BIT+1 clocks apart.
REQ-018 pid_out SHALL hold the popped PID for the whole HOLD state and SHALL be 8'h00 otherwise.
REQ-019 Push when full without simultaneous pop: request SHALL be dropped, overflow set to 1 and held until reset.
REQ-020 Simultaneous push and pop when full: both SHALL occur, pending unchanged, overflow unchanged.
REQ-021 Queue pointers SHALL wrap modulo DEPTH; order SHALL be strictly FIFO.
REQ-022 The bit-period counter SHALL be CLKS_PER_BIT wide enough ($clog2(CLKS_PER_BIT)) and SHALL reload at every state entry.

Reset
REQ-023 With rst=1 at a clock edge: state=IDLE, queue empty, pending=0, slow_enable=0, pid_out=8'h00, overflow=0, counter=0.
REQ-024 rst asserted mid-HOLD SHALL abort the pulse; slow_enable=0 from the next clock, queued PIDs discarded.
REQ-025 fast_enable coincident with rst SHALL be ignored.

Configuration
REQ-026 Macro PID_CHECK_EN SHALL, when defined, reject pid_in=4'b0000 (reserved): not queued, overflow unaffected, no slow_enable pulse.
REQ-027 Without PID_CHECK_EN, every PID value SHALL be accepted identically.

Structure
REQ-028 A shared package pid_pkg SHALL hold the state enum (IDLE, HOLD, GAP), the 4-bit PID typedef and the reserved-PID constant.
REQ-029 The bit-period count SHALL use one sub-module, flex_counter, with parameterised rollover value CLKS_PER_BIT.
REQ-030 Queue storage SHALL be flops inside pid_fast_stretch; no other sub-module.

Verification
REQ-031 Single request: fast_enable with pid_in=4'h1 at clock 10 -> slow_enable=1 clocks 12-19, pid_out=8'hE1, pending back to 0.
REQ-032 Burst: 3 consecutive fast_enable (4'h1, 4'h9, 4'h2) -> three 8-clock pulses, rising edges 17 apart, pid_out E1, 69, D2 in order.
REQ-033 Overflow: 6 consecutive requests while HOLD, DEPTH=4 -> pending peaks at 4, 5th/6th dropped, overflow=1 until rst.
REQ-034 Reset mid-HOLD: rst at HOLD clock 3 -> slow_enable=0 next clock, pending=0, later single request behaves as REQ-031.
REQ-035 PID_CHECK_EN defined: request with pid_in=4'h0 -> no pulse, pending stays 0; undefined -> pulse with pid_out=8'hF0.
REQ-036 Full with simultaneous pop: queue at 4, push on pop clock -> pending stays 4, overflow stays 0.

Source files
------------

// File: rtl/pid_pkg.sv
// pid_pkg: shared FSM states, PID type, reserved-PID constant and PID wire encoding
package pid_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_e;

    typedef logic [3:0] pid_t;

    localparam pid_t PID_RESERVED = 4'h0;

    function automatic logic [7:0] pid_encode(input pid_t pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/flex_counter.sv
// flex_counter: bit-period counter wrapping at ROLLOVER-1, reloaded to zero by clear_i
module flex_counter #(
    parameter int ROLLOVER = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic roll_o
);

    localparam int W = $clog2(ROLLOVER);

    logic [W-1:0] count_q, count_d;

    assign roll_o = count_q == W'(ROLLOVER - 1);

    // next count: clear wins, otherwise advance and wrap on the last count of the period
    always_comb count_d = clear_i ? '0 : !en_i ? count_q : roll_o ? '0 : count_q + W'(1);

    // count register
    always_ff @(posedge clk)
        if (rst) count_q <= '0;
        else     count_q <= count_d;

endmodule

// File: rtl/pid_fast_stretch.sv
// pid_fast_stretch: queues single-cycle PID requests and replays each as a one-bit-period enable pulse.
// Define PID_CHECK_EN to reject the reserved PID 4'h0 at the input.
module pid_fast_stretch
    import pid_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int DEPTH        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fast_enable,
    input  logic [3:0]             pid_in,
    output logic                   slow_enable,
    output logic [7:0]             pid_out,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pid_t          mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cnt_d;
    pid_t          pid_q;
    logic          overflow_q;
    state_e        state_q, state_d;
    logic          pid_ok, full, push, pop, drop;
    logic          tmr_clear, tmr_en, tmr_roll;

`ifdef PID_CHECK_EN
    assign pid_ok = pid_in != PID_RESERVED;
`else
    assign pid_ok = 1'b1;
`endif

    assign full = cnt_q == CW'(DEPTH);
    assign pop  = state_q == IDLE && cnt_q != '0;
    assign push = fast_enable && pid_ok && (!full || pop);
    assign drop = fast_enable && pid_ok && full && !pop;

    assign slow_enable = state_q == HOLD;
    assign pid_out     = state_q == HOLD ? pid_encode(pid_q) : 8'h00;
    assign pending     = cnt_q;
    assign overflow    = overflow_q;

    // occupancy follows push/pop; a simultaneous push and pop leaves it unchanged
    always_comb cnt_d = (push && !pop) ? cnt_q + CW'(1) : (pop && !push) ? cnt_q - CW'(1) : cnt_q;

    // queue storage; contents are meaningless once pointers are reset
    always_ff @(posedge clk)
        if (push) mem_q[wr_q] <= pid_in;

    // queue pointers, occupancy, presented PID and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            pid_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop) begin
                rd_q  <= rd_q + AW'(1);
                pid_q <= mem_q[rd_q];
            end
            cnt_q <= cnt_d;
            if (drop) overflow_q <= 1'b1;
        end
    end

    // state register
    always_ff @(posedge clk)
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;

    // next state and timer control; the timer restarts at every state entry
    always_comb begin
        state_d   = state_q;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                tmr_clear = 1'b1;
                if (pop) state_d = HOLD;
            end
            HOLD: begin
                tmr_en = 1'b1;
                if (tmr_roll) begin
                    state_d   = GAP;
                    tmr_clear = 1'b1;
                end
            end
            GAP: begin
                tmr_en = 1'b1;
                if (tmr_roll) begin
                    state_d   = IDLE;
                    tmr_clear = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                tmr_clear = 1'b1;
            end
        endcase
    end

    flex_counter #(.ROLLOVER(CLKS_PER_BIT)) u_tmr (
        .clk     (clk),
        .rst     (rst),
        .clear_i (tmr_clear),
        .en_i    (tmr_en),
        .roll_o  (tmr_roll)
    );

endmodule

// File: tb/tb_pid_fast_stretch.sv
// tb_pid_fast_stretch: scoreboard bench for pid_fast_stretch at CLKS_PER_BIT=8, DEPTH=4
module tb_pid_fast_stretch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fast_enable = 1'b0;
    logic [3:0] pid_in = 4'h0;
    logic       slow_enable;
    logic [7:0] pid_out;
    logic [2:0] pending;
    logic       overflow;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    int         rises[$];

    pid_fast_stretch #(.CLKS_PER_BIT(8), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .fast_enable (fast_enable),
        .pid_in      (pid_in),
        .slow_enable (slow_enable),
        .pid_out     (pid_out),
        .pending     (pending),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [3:0] p, input bit accept);
        fast_enable = 1'b1;
        pid_in      = p;
        if (accept) exp_q.push_back({~p, p});
        tick();
        fast_enable = 1'b0;
    endtask

    task automatic single(input logic [3:0] p);
        req(p, 1'b1);
        check("single_pend_t", pending, 1);
        check("single_se_t", slow_enable, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check("single_hold", slow_enable, 1);
            check("single_pid", pid_out, {~p, p});
            tick();
        end
        check("single_end_se", slow_enable, 0);
        check("single_end_pid", pid_out, 8'h00);
        check("single_end_pend", pending, 0);
    endtask

    // monitor: pop expected PID at each rising slow_enable, check width and idle pid_out
    initial begin
        int         width;
        logic       prev_se;
        logic [7:0] e;
        width   = 0;
        prev_se = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                width   = 0;
                prev_se = 1'b0;
                exp_q.delete();
            end else begin
                if (slow_enable && !prev_se) begin
                    rises.push_back(cyc);
                    if (exp_q.size() == 0) check("unexpected_pulse", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("pid_order", pid_out, e);
                    end
                end
                if (slow_enable) width++;
                if (!slow_enable && prev_se) begin
                    check("pulse_width", width, 8);
                    check("pid_idle", pid_out, 8'h00);
                    width = 0;
                end
                prev_se = slow_enable;
            end
        end
    end

    initial begin
        // reset with a coincident request that must be ignored
        fast_enable = 1'b1;
        pid_in      = 4'h5;
        repeat (2) tick();
        rst         = 1'b0;
        fast_enable = 1'b0;
        check("rst_se", slow_enable, 0);
        check("rst_pid", pid_out, 8'h00);
        check("rst_pend", pending, 0);
        check("rst_ovf", overflow, 0);
        repeat (3) tick();
        check("rst_req_ignored", pending, 0);

        single(4'h1);
        repeat (10) tick();

        // back-to-back burst
        rises.delete();
        req(4'h1, 1'b1);
        req(4'h9, 1'b1);
        req(4'h2, 1'b1);
        repeat (60) tick();
        check("burst_pulses", rises.size(), 3);
        if (rises.size() == 3) begin
            check("burst_gap1", rises[1] - rises[0], 17);
            check("burst_gap2", rises[2] - rises[1], 17);
        end

        // overflow while presenting
        req(4'hA, 1'b1);
        repeat (2) tick();
        for (int i = 0; i < 6; i++) begin
            req(4'(3 + i), i < 4);
            check("ovf_pend", pending, (i < 4) ? i + 1 : 4);
            check("ovf_flag", overflow, i >= 4);
        end
        repeat (90) tick();
        check("ovf_sticky", overflow, 1);
        check("ovf_drained", pending, 0);

        // full queue with a push on the pop clock
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("full_rst_ovf", overflow, 0);
        req(4'hB, 1'b1);
        repeat (2) tick();
        req(4'hC, 1'b1);
        req(4'hD, 1'b1);
        req(4'hE, 1'b1);
        req(4'hF, 1'b1);
        repeat (11) tick();
        check("full_pend_before", pending, 4);
        check("full_se_before", slow_enable, 0);
        req(4'h7, 1'b1);
        check("full_pend_after", pending, 4);
        check("full_ovf_after", overflow, 0);
        check("full_se_after", slow_enable, 1);
        repeat (100) tick();
        check("full_drained", pending, 0);

        // reset on the third HOLD clock
        req(4'h4, 1'b1);
        req(4'h5, 1'b1);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_se", slow_enable, 0);
        check("midrst_pend", pending, 0);
        check("midrst_pid", pid_out, 8'h00);
        repeat (20) tick();
        single(4'h1);
        repeat (20) tick();

        // reserved PID
`ifdef PID_CHECK_EN
        req(4'h0, 1'b0);
        check("rsvd_pend", pending, 0);
        repeat (20) tick();
        check("rsvd_ovf", overflow, 0);
`else
        single(4'h0);
        repeat (20) tick();
`endif

        check("exp_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
